alu_seq: RTL

- Parametrised, registered successor to the Gumnut combinational ALU.
- Keeps the arithmetic, logic and shift op groups, and generalises operand width via WIDTH.
- Adds an iterative shifter (1 bit/cycle) and an iterative unsigned multiplier behind a start/ready/done handshake.
- Sits in the core execute stage; the control FSM stalls on ready_o and writes back on done_o.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_iter.sv | 89 ++++++++
 rtl/alu_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op-group encodings and FSM state type for alu_seq
package alu_pkg;

    localparam logic [1:0] GRP_ARITH = 2'b00;
    localparam logic [1:0] GRP_LOGIC = 2'b01;
    localparam logic [1:0] GRP_SHIFT = 2'b10;
    localparam logic [1:0] GRP_EXT   = 2'b11;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDC = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_SUBC = 2'b11;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_MASK = 2'b11;

    localparam logic [1:0] OP_SHL  = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_ROL  = 2'b10;
    localparam logic [1:0] OP_ROR  = 2'b11;

    localparam logic [1:0] OP_MUL  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        MUL
    } state_t;

endpackage

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - iterative shift/multiply datapath with shared step counter
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               load,
    input  logic               step,
    input  logic               load_mul,
    input  logic [1:0]         load_op,
    input  logic [WIDTH-1:0]   rs,
    input  logic [WIDTH-1:0]   op2,
    input  logic [CNT_W-1:0]   count,
    output logic [WIDTH-1:0]   shift_nxt,
    output logic               shift_out,
    output logic [2*WIDTH-1:0] prod_nxt,
    output logic               last_step
);

    logic [WIDTH-1:0]   sreg_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;

    logic [1:0]         op_cur;
    logic [WIDTH-1:0]   src;
    logic [WIDTH-1:0]   a_hi;
    logic [WIDTH-1:0]   a_lo;
    logic [WIDTH-1:0]   m;
    logic [WIDTH:0]     sum;

    // The load edge already performs the first step, straight from the operand inputs.
    always_comb begin
        op_cur = load ? load_op : op_q;
        src    = load ? rs : sreg_q;
        case (op_cur)
            OP_SHL: begin
                shift_nxt = {src[WIDTH-2:0], 1'b0};
                shift_out = src[WIDTH-1];
            end
            OP_SHR: begin
                shift_nxt = {1'b0, src[WIDTH-1:1]};
                shift_out = src[0];
            end
            OP_ROL: begin
                shift_nxt = {src[WIDTH-2:0], src[WIDTH-1]};
                shift_out = src[WIDTH-1];
            end
            default: begin
                shift_nxt = {src[0], src[WIDTH-1:1]};
                shift_out = src[0];
            end
        endcase

        a_hi     = load ? '0 : acc_q[2*WIDTH-1:WIDTH];
        a_lo     = load ? rs : acc_q[WIDTH-1:0];
        m        = load ? op2 : mcand_q;
        sum      = {1'b0, a_hi} + (a_lo[0] ? {1'b0, m} : '0);
        prod_nxt = {sum, a_lo[WIDTH-1:1]};

        last_step = load ? (!load_mul && (count == CNT_W'(1))) : (cnt_q == CNT_W'(1));
    end

    // cnt_q holds the number of steps still to run after the current edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sreg_q  <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
        end else if (load || step) begin
            sreg_q <= shift_nxt;
            acc_q  <= prod_nxt;
            if (load) begin
                mcand_q <= op2;
                op_q    <= load_op;
                cnt_q   <= load_mul ? CNT_W'(WIDTH - 1) : count - CNT_W'(1);
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with single-cycle ops and iterative shift/multiply
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] op2_i,
    input  logic [3:0]       ALUOp_i,
    input  logic             carry_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] res_o,
    output logic [WIDTH-1:0] res_hi_o,
    output logic             carry_o,
    output logic             zero_o
);

    state_t             state_q, state_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   res_q, res_d, hi_q, hi_d;
    logic               c_q, c_d, zero_q, upd;
    logic               load, step, it_last, shift_out;
    logic [WIDTH-1:0]   shift_nxt, logic_res;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH:0]     arith, ext_rs, ext_op2, ext_cin;
    logic [1:0]         grp, op;

    assign grp = ALUOp_i[3:2];
    assign op  = ALUOp_i[1:0];

    alu_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .load      (load),
        .step      (step),
        .load_mul  (grp == GRP_EXT),
        .load_op   (op),
        .rs        (rs_i),
        .op2       (op2_i),
        .count     (count_i),
        .shift_nxt (shift_nxt),
        .shift_out (shift_out),
        .prod_nxt  (prod_nxt),
        .last_step (it_last)
    );

    // Subtraction at WIDTH+1 bits leaves the borrow in the top bit.
    always_comb begin
        ext_rs  = {1'b0, rs_i};
        ext_op2 = {1'b0, op2_i};
        ext_cin = {{WIDTH{1'b0}}, carry_i};
        case (op)
            OP_ADD:  arith = ext_rs + ext_op2;
            OP_ADDC: arith = ext_rs + ext_op2 + ext_cin;
            OP_SUB:  arith = ext_rs - ext_op2;
            default: arith = ext_rs - ext_op2 - ext_cin;
        endcase
        case (op)
            OP_AND:  logic_res = rs_i & op2_i;
            OP_OR:   logic_res = rs_i | op2_i;
            OP_XOR:  logic_res = rs_i ^ op2_i;
            default: logic_res = rs_i & ~op2_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        upd     = 1'b0;
        res_d   = '0;
        hi_d    = '0;
        c_d     = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    case (grp)
                        GRP_ARITH: begin
                            upd          = 1'b1;
                            done_d       = 1'b1;
                            {c_d, res_d} = arith;
                        end
                        GRP_LOGIC: begin
                            upd    = 1'b1;
                            done_d = 1'b1;
                            res_d  = logic_res;
                        end
                        GRP_SHIFT: begin
                            if (count_i == '0) begin
                                upd    = 1'b1;
                                done_d = 1'b1;
                                res_d  = rs_i;
                            end else begin
                                load = 1'b1;
                                if (it_last) begin
                                    upd    = 1'b1;
                                    done_d = 1'b1;
                                    res_d  = shift_nxt;
                                    c_d    = shift_out;
                                end else begin
                                    state_d = SHIFT;
                                end
                            end
                        end
                        default: begin
                            if (op == OP_MUL) begin
                                load    = 1'b1;
                                state_d = MUL;
                            end else begin
                                upd    = 1'b1;
                                done_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (it_last) begin
                    upd     = 1'b1;
                    done_d  = 1'b1;
                    res_d   = shift_nxt;
                    c_d     = shift_out;
                    state_d = IDLE;
                end
            end
            MUL: begin
                step = 1'b1;
                if (it_last) begin
                    upd           = 1'b1;
                    done_d        = 1'b1;
                    {hi_d, res_d} = prod_nxt;
                    c_d           = |prod_nxt[2*WIDTH-1:WIDTH];
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            res_q   <= '0;
            hi_q    <= '0;
            c_q     <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (upd) begin
                res_q  <= res_d;
                hi_q   <= hi_d;
                c_q    <= c_d;
                zero_q <= (res_d == '0);
            end
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign done_o   = done_q;
    assign res_o    = res_q;
    assign res_hi_o = hi_q;
    assign carry_o  = c_q;
    assign zero_o   = zero_q;

endmodule
